// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared constants and helpers for the quadrature encoder path
package quad_pkg;

  localparam int QUAD_DEBOUNCE_DEFAULT = 16;

  // Counter width able to hold 0..cycles, never narrower than one bit.
  function automatic int quad_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/quad_debounce_chan.sv
// rtl/quad_debounce_chan.sv - one encoder channel: 2-flop synchroniser plus stable-count debounce
module quad_debounce_chan
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = QUAD_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic f,
  output logic chg
);

  localparam int CNT_W = quad_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // chg is decoded from flops only, so it marks the edge at which f will update
  // and lets the top register its classification alongside f.
  assign chg = (sync2 != f) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      f     <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == f) begin
        cnt <= '0;
      end else if (chg) begin
        f   <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - synchronise and debounce encoder A/B, flag steps and illegal double changes
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = QUAD_DEBOUNCE_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_A,
  input  logic i_B,
  input  logic i_Err_Clr,
  output logic o_A,
  output logic o_B,
  output logic o_Step,
  output logic o_Err,
  output logic o_Err_Sticky
);

  logic chg_a;
  logic chg_b;
  logic both;

  quad_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
    .clk (i_Clk),
    .rst (i_Rst),
    .raw (i_A),
    .f   (o_A),
    .chg (chg_a)
  );

  quad_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
    .clk (i_Clk),
    .rst (i_Rst),
    .raw (i_B),
    .f   (o_B),
    .chg (chg_b)
  );

  assign both = chg_a & chg_b;

  // A simultaneous change on both channels is an illegal Gray transition;
  // a new error beats a clear arriving on the same edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Step       <= 1'b0;
      o_Err        <= 1'b0;
      o_Err_Sticky <= 1'b0;
    end else begin
      o_Step <= chg_a ^ chg_b;
      o_Err  <= both;
      if (both) begin
        o_Err_Sticky <= 1'b1;
      end else if (i_Err_Clr) begin
        o_Err_Sticky <= 1'b0;
      end
    end
  end

endmodule
